// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port 4K x 32 memory between fetch, data and loader ports; adds a load-mode stall FSM.
// Latency: the grant and memory controls are combinational; read data is valid one cycle after the grant (r_*valid).
// Backpressure: an ungranted requester holds its request and payload; fetch beats data after STARVE_MAX denials.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 12,
  parameter int DW         = 32
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic          w_ireq,
  input  logic [AW-1:0] w_iaddr,
  output logic          w_igrant,
  output logic          r_ivalid,
  input  logic          w_dreq,
  input  logic          w_dwe,
  input  logic [AW-1:0] w_daddr,
  input  logic [DW-1:0] w_dwdata,
  output logic          w_dgrant,
  output logic          r_dvalid,
  input  logic          w_lreq,
  input  logic          w_lwe,
  input  logic [AW-1:0] w_laddr,
  input  logic [DW-1:0] w_lwdata,
  output logic          w_lgrant,
  output logic          r_lvalid,
  input  logic          w_load_mode,
  output logic          r_busy_load,
  output logic [AW-1:0] w_maddr,
  output logic          w_mwe,
  output logic [DW-1:0] w_mdin,
  input  logic [DW-1:0] w_mdout,
  output logic [DW-1:0] w_rdata,
  output logic [15:0]   r_conflicts
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_istarve;
  logic [1:0] w_req_cnt;
  logic       w_contend;

  // Next-state decode and the single grant: fixed priority data > fetch unless fetch has starved.
  always_comb begin
    w_state_nxt = r_state;
    w_igrant    = 1'b0;
    w_dgrant    = 1'b0;
    w_lgrant    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_load_mode) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_ireq && w_dreq) begin
          if (r_istarve >= STARVE_LIM) w_igrant = 1'b1;
          else                         w_dgrant = 1'b1;
        end else begin
          w_igrant = w_ireq;
          w_dgrant = w_dreq;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_load_mode) w_lgrant = w_lreq;
        else             w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Memory port mux: idle bus drives zeros so the memory sees a quiet address when nobody is granted.
  always_comb begin
    w_maddr = '0;
    w_mdin  = '0;
    w_mwe   = 1'b0;
    if (w_igrant) begin
      w_maddr = w_iaddr;
    end else if (w_dgrant) begin
      w_maddr = w_daddr;
      w_mdin  = w_dwdata;
      w_mwe   = w_dwe;
    end else if (w_lgrant) begin
      w_maddr = w_laddr;
      w_mdin  = w_lwdata;
      w_mwe   = w_lwe;
    end
  end

  assign w_rdata = w_mdout;

  // The loader only competes while LOAD is active; in RUN its request is simply ignored.
  assign w_req_cnt = {1'b0, w_ireq} + {1'b0, w_dreq}
                   + {1'b0, w_lreq & (r_state == ST_LOAD)};
  assign w_contend = (w_req_cnt >= 2'd2);

  // State register plus the stall flag, registered from the next-state decode.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state     <= ST_RUN;
      r_busy_load <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy_load <= (w_state_nxt != ST_RUN);
    end
  end

  // Fetch starvation counter: counts denied fetch cycles in RUN, frozen while loading.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_istarve <= 8'd0;
    end else if (r_state == ST_RUN) begin
      if (w_ireq && !w_igrant) begin
        if (r_istarve < STARVE_LIM) r_istarve <= r_istarve + 8'd1;
      end else begin
        r_istarve <= 8'd0;
      end
    end
  end

  // Read-valid return: one pulse per granted read, never for writes.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_ivalid <= 1'b0;
      r_dvalid <= 1'b0;
      r_lvalid <= 1'b0;
    end else begin
      r_ivalid <= w_igrant;
      r_dvalid <= w_dgrant & ~w_dwe;
      r_lvalid <= w_lgrant & ~w_lwe;
    end
  end

  // Saturating contention counter.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_conflicts <= 16'd0;
    end else if (w_contend && (r_conflicts != 16'hFFFF)) begin
      r_conflicts <= r_conflicts + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, directed plan steps and a randomized run.
// Latency: the model predicts grants in the current cycle and valid/rdata one cycle later.
// Backpressure: requests are held by the stimulus; the model tracks starvation and load mode.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SM = 4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_LOAD = 2;
  localparam int G_NONE = 0, G_I = 1, G_D = 2, G_L = 3;

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic          w_ireq, w_dreq, w_dwe, w_lreq, w_lwe, w_load_mode;
  logic [AW-1:0] w_iaddr, w_daddr, w_laddr;
  logic [DW-1:0] w_dwdata, w_lwdata;
  logic          w_igrant, w_dgrant, w_lgrant;
  logic          r_ivalid, r_dvalid, r_lvalid, r_busy_load;
  logic [AW-1:0] w_maddr;
  logic          w_mwe;
  logic [DW-1:0] w_mdin, w_mdout, w_rdata;
  logic [15:0]   r_conflicts;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 w_clk = ~w_clk;

  mem_port_arbiter #(.STARVE_MAX(SM), .AW(AW), .DW(DW)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_ireq(w_ireq), .w_iaddr(w_iaddr), .w_igrant(w_igrant), .r_ivalid(r_ivalid),
    .w_dreq(w_dreq), .w_dwe(w_dwe), .w_daddr(w_daddr), .w_dwdata(w_dwdata),
    .w_dgrant(w_dgrant), .r_dvalid(r_dvalid),
    .w_lreq(w_lreq), .w_lwe(w_lwe), .w_laddr(w_laddr), .w_lwdata(w_lwdata),
    .w_lgrant(w_lgrant), .r_lvalid(r_lvalid),
    .w_load_mode(w_load_mode), .r_busy_load(r_busy_load),
    .w_maddr(w_maddr), .w_mwe(w_mwe), .w_mdin(w_mdin), .w_mdout(w_mdout),
    .w_rdata(w_rdata), .r_conflicts(r_conflicts)
  );

  function automatic logic [DW-1:0] init_word(int i);
    if (i == 3) return 32'h2009_0001;
    return 32'hA500_0000 | DW'(i);
  endfunction

  // Behavioural single-port synchronous memory, preloaded on the first edge (held in reset then).
  logic [DW-1:0] mem [0:4095];
  logic          mem_ready = 1'b0;
  always @(posedge w_clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      if (w_mwe) mem[w_maddr] <= w_mdin;
      w_mdout <= mem[w_maddr];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:4095];
  int            m_mode, m_starve, m_conf;
  bit            e_iv, e_dv, e_lv, e_busy;
  logic [DW-1:0] e_rdata;
  int            obs_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_starve = 0; m_conf = 0;
    e_iv = 0; e_dv = 0; e_lv = 0; e_busy = 0;
  endtask

  task automatic idle_inputs();
    w_ireq = 0; w_dreq = 0; w_dwe = 0; w_lreq = 0; w_lwe = 0; w_load_mode = 0;
    w_iaddr = '0; w_daddr = '0; w_laddr = '0; w_dwdata = '0; w_lwdata = '0;
  endtask

  // One clock: check combinational outputs and registered state at negedge, then advance the model.
  task automatic do_cycle();
    int g, nreq, nxt;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    bit we;
    @(negedge w_clk);
    g = G_NONE;
    if (m_mode == M_RUN && !w_load_mode) begin
      if (w_ireq && w_dreq) g = (m_starve >= SM) ? G_I : G_D;
      else if (w_ireq)      g = G_I;
      else if (w_dreq)      g = G_D;
    end else if (m_mode == M_LOAD && w_load_mode && w_lreq) begin
      g = G_L;
    end
    a = '0; wd = '0; we = 0;
    if (g == G_I) a = w_iaddr;
    if (g == G_D) begin a = w_daddr; wd = w_dwdata; we = w_dwe; end
    if (g == G_L) begin a = w_laddr; wd = w_lwdata; we = w_lwe; end
    obs_g = w_igrant ? G_I : w_dgrant ? G_D : w_lgrant ? G_L : G_NONE;
    chk("igrant", 32'(w_igrant), 32'(g == G_I));
    chk("dgrant", 32'(w_dgrant), 32'(g == G_D));
    chk("lgrant", 32'(w_lgrant), 32'(g == G_L));
    chk("maddr", 32'(w_maddr), 32'(a));
    chk("mwe", 32'(w_mwe), 32'(we));
    chk("mdin", w_mdin, wd);
    chk("ivalid", 32'(r_ivalid), 32'(e_iv));
    chk("dvalid", 32'(r_dvalid), 32'(e_dv));
    chk("lvalid", 32'(r_lvalid), 32'(e_lv));
    if (e_iv || e_dv || e_lv) chk("rdata", w_rdata, e_rdata);
    chk("busy", 32'(r_busy_load), 32'(e_busy));
    chk("conflicts", 32'(r_conflicts), 32'(m_conf));
    @(posedge w_clk);
    nreq = int'(w_ireq) + int'(w_dreq) + ((m_mode == M_LOAD) ? int'(w_lreq) : 0);
    if (nreq >= 2 && m_conf < 65535) m_conf++;
    e_iv = (g == G_I);
    e_dv = (g == G_D) && !we;
    e_lv = (g == G_L) && !we;
    if (g != G_NONE) begin
      if (we) ref_mem[a] = wd;
      else    e_rdata = ref_mem[a];
    end
    if (m_mode == M_RUN) begin
      if (w_ireq && g != G_I) begin
        if (m_starve < SM) m_starve++;
      end else begin
        m_starve = 0;
      end
    end
    case (m_mode)
      M_RUN:   nxt = w_load_mode ? M_DRAIN : M_RUN;
      M_DRAIN: nxt = M_LOAD;
      default: nxt = w_load_mode ? M_LOAD : M_RUN;
    endcase
    m_mode = nxt;
    e_busy = (nxt != M_RUN);
    #1;
  endtask

  int pat [6] = '{G_D, G_D, G_D, G_D, G_I, G_D};
  int c0;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    idle_inputs();
    w_rst = 1'b1;
    model_reset();
    repeat (2) @(posedge w_clk);
    #1 w_rst = 1'b0;

    // Reset state
    chk("rst_ivalid", 32'(r_ivalid), 0);
    chk("rst_dvalid", 32'(r_dvalid), 0);
    chk("rst_lvalid", 32'(r_lvalid), 0);
    chk("rst_busy", 32'(r_busy_load), 0);
    chk("rst_conflicts", 32'(r_conflicts), 0);

    // Reset mid-read: fetch of addr 5 granted, reset held across the edge that would return it
    w_ireq = 1; w_iaddr = 12'd5;
    @(negedge w_clk);
    chk("midrd_igrant", 32'(w_igrant), 1);
    w_rst = 1'b1;
    @(posedge w_clk);
    #1 w_rst = 1'b0; w_ireq = 0;
    model_reset();
    chk("midrd_ivalid", 32'(r_ivalid), 0);
    chk("midrd_conflicts", 32'(r_conflicts), 0);
    chk("midrd_busy", 32'(r_busy_load), 0);
    do_cycle();

    // Single requester: fetch addr 3
    w_ireq = 1; w_iaddr = 12'd3;
    do_cycle();
    chk("single_igrant", 32'(obs_g), G_I);
    w_ireq = 0;
    chk("single_ivalid", 32'(r_ivalid), 1);
    chk("single_rdata", w_rdata, 32'h2009_0001);
    do_cycle();

    // Contention with starvation relief
    w_ireq = 1; w_iaddr = 12'd7; w_dreq = 1; w_dwe = 0; w_daddr = 12'd20;
    for (int k = 0; k < 6; k++) begin
      do_cycle();
      chk("contend_seq", 32'(obs_g), 32'(pat[k]));
    end
    w_ireq = 0; w_dreq = 0;
    chk("contend_conflicts", 32'(r_conflicts), 6);
    do_cycle();

    // Store then load at addr 10
    w_dreq = 1; w_dwe = 1; w_daddr = 12'd10; w_dwdata = 32'h0000_00AB;
    do_cycle();
    chk("store_no_valid", 32'(r_dvalid), 0);
    w_dwe = 0;
    do_cycle();
    chk("load_dvalid", 32'(r_dvalid), 1);
    chk("load_rdata", w_rdata, 32'h0000_00AB);
    w_dreq = 0;
    do_cycle();

    // Load mode entry, loader write/read, exit
    w_ireq = 1; w_iaddr = 12'd1;
    do_cycle();
    w_load_mode = 1;
    do_cycle();
    chk("lm_masked", 32'(obs_g), G_NONE);
    chk("lm_busy_rise", 32'(r_busy_load), 1);
    do_cycle();
    chk("lm_drain", 32'(obs_g), G_NONE);
    w_ireq = 0;
    w_lreq = 1; w_lwe = 1; w_laddr = 12'd0; w_lwdata = 32'hDEAD_BEEF;
    do_cycle();
    chk("lm_lwrite", 32'(obs_g), G_L);
    w_lwe = 0;
    do_cycle();
    chk("lm_lvalid", 32'(r_lvalid), 1);
    chk("lm_rdata", w_rdata, 32'hDEAD_BEEF);
    w_lreq = 0; w_load_mode = 0; w_ireq = 1;
    do_cycle();
    chk("lm_exit_idle", 32'(obs_g), G_NONE);
    chk("lm_busy_fall", 32'(r_busy_load), 0);
    do_cycle();
    chk("lm_fetch_resume", 32'(obs_g), G_I);

    // Loader ignored in RUN
    w_lreq = 1; w_lwe = 1; w_laddr = 12'd9; w_lwdata = 32'h1234_5678;
    c0 = m_conf;
    do_cycle();
    chk("run_lreq_grant", 32'(obs_g), G_I);
    chk("run_lreq_conf", 32'(r_conflicts), 32'(c0));
    idle_inputs();
    do_cycle();

    // Randomized traffic on a small address window so reads hit earlier writes
    for (int n = 0; n < 2000; n++) begin
      w_ireq   = 1'($urandom_range(0, 1));
      w_iaddr  = AW'($urandom_range(0, 31));
      w_dreq   = 1'($urandom_range(0, 1));
      w_dwe    = 1'($urandom_range(0, 1));
      w_daddr  = AW'($urandom_range(0, 31));
      w_dwdata = $urandom;
      w_lreq   = 1'($urandom_range(0, 1));
      w_lwe    = 1'($urandom_range(0, 1));
      w_laddr  = AW'($urandom_range(0, 31));
      w_lwdata = $urandom;
      if ($urandom_range(0, 15) == 0) w_load_mode = ~w_load_mode;
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
